approx_adder_err_monitor: RTL and testbench



---
 rtl/approx_adder_err_monitor.sv | 92 +++++++++
 tb/tb_approx_adder_err_monitor.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/approx_adder_err_monitor.sv
// approx_adder_err_monitor: sweeps all 16 vectors of a 2+2-bit approximate adder and gathers error stats.
// Optional ERR_MONITOR_STOP_ON_FAIL_EN ends the sweep at the first vector whose error exceeds ET.
module approx_adder_err_monitor #(
    parameter logic [2:0] ET = 3'd2,
    parameter int SETTLE = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [3:0] dut_in,
    input  logic [2:0] dut_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] max_err,
    output logic [4:0] err_cnt,
    output logic [4:0] viol_cnt,
    output logic [6:0] err_sum,
    output logic [3:0] first_viol
);
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
    localparam logic [2:0] SW = 3'(SETTLE);
    state_t state, state_n;
    logic [2:0] wait_cnt, exact, err;
    logic [4:0] viol_n;
    logic viol, stop;
    always_comb begin
        exact = {1'b0, dut_in[1:0]} + {1'b0, dut_in[3:2]};
        err = exact >= dut_out ? exact - dut_out : dut_out - exact;
        viol = err > ET;
        viol_n = viol_cnt + 5'(viol);
`ifdef ERR_MONITOR_STOP_ON_FAIL_EN
        stop = viol;
`else
        stop = 1'b0;
`endif
        state_n = state;
        case (state)
            IDLE:   state_n = start ? DRIVE : IDLE;
            DRIVE:  state_n = wait_cnt == SW ? SAMPLE : DRIVE;
            SAMPLE: state_n = (dut_in == 4'd15 || stop) ? DONE : DRIVE;
            DONE:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    // dut_in doubles as the vector index
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            wait_cnt <= '0;
            dut_in <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            pass <= 1'b0;
            max_err <= '0;
            err_cnt <= '0;
            viol_cnt <= '0;
            err_sum <= '0;
            first_viol <= '0;
        end else begin
            state <= state_n;
            done <= state_n == DONE;
            busy <= state_n == DRIVE || state_n == SAMPLE;
            case (state)
                IDLE: if (start) begin
                    wait_cnt <= '0;
                    dut_in <= '0;
                    pass <= 1'b0;
                    max_err <= '0;
                    err_cnt <= '0;
                    viol_cnt <= '0;
                    err_sum <= '0;
                    first_viol <= '0;
                end
                DRIVE: wait_cnt <= wait_cnt + 3'd1;
                SAMPLE: begin
                    max_err <= err > max_err ? err : max_err;
                    err_cnt <= err_cnt + 5'(err != 3'd0);
                    err_sum <= err_sum + 7'(err);
                    viol_cnt <= viol_n;
                    if (viol && viol_cnt == 5'd0) first_viol <= dut_in;
                    if (state_n == DRIVE) begin
                        dut_in <= dut_in + 4'd1;
                        wait_cnt <= '0;
                    end
                    if (state_n == DONE) pass <= viol_n == 5'd0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_approx_adder_err_monitor.sv
// tb_approx_adder_err_monitor: directed checks of the error monitor around behavioural adder models.
module tb_approx_adder_err_monitor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0, start1 = 1'b0;
    int mode = 0;
    int checks = 0, errors = 0;
    logic [3:0] din0, din1, fv0, fv1;
    logic [2:0] dout0, dout1, me0, me1;
    logic [4:0] ec0, ec1, vc0, vc1;
    logic [6:0] es0, es1;
    logic busy0, busy1, done0, done1, pass0, pass1;

    always #5 clk = ~clk;

    // mode 0 exact, 1 tied to zero, 2 err 2 on vec 9, 3 err 1 everywhere
    function automatic logic [2:0] model(int m, logic [3:0] v);
        logic [2:0] e;
        e = {1'b0, v[1:0]} + {1'b0, v[3:2]};
        if (m == 1) return 3'd0;
        if (m == 2) return v == 4'd9 ? e - 3'd2 : e;
        if (m == 3) return e ^ 3'd1;
        return e;
    endfunction

    assign dout0 = model(mode, din0);
    assign dout1 = model(mode, din1);

    approx_adder_err_monitor #(.ET(3'd2), .SETTLE(0)) u0 (
        .clk(clk), .rst(rst), .start(start0), .dut_in(din0), .dut_out(dout0),
        .busy(busy0), .done(done0), .pass(pass0), .max_err(me0), .err_cnt(ec0),
        .viol_cnt(vc0), .err_sum(es0), .first_viol(fv0));

    approx_adder_err_monitor #(.ET(3'd2), .SETTLE(3)) u1 (
        .clk(clk), .rst(rst), .start(start1), .dut_in(din1), .dut_out(dout1),
        .busy(busy1), .done(done1), .pass(pass1), .max_err(me1), .err_cnt(ec1),
        .viol_cnt(vc1), .err_sum(es1), .first_viol(fv1));

    task automatic chk(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_stats(string tag, int p, int me, int ec, int vc, int es, int fv);
        chk({tag, " pass"}, int'(pass0), p);
        chk({tag, " max_err"}, int'(me0), me);
        chk({tag, " err_cnt"}, int'(ec0), ec);
        chk({tag, " viol_cnt"}, int'(vc0), vc);
        chk({tag, " err_sum"}, int'(es0), es);
        chk({tag, " first_viol"}, int'(fv0), fv);
    endtask

    // pulse start0 on one edge, then count cycles until done0 (0 on timeout)
    task automatic sweep0(output int cyc);
        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        chk("busy after start", int'(busy0), 1);
        chk("dut_in after start", int'(din0), 0);
        cyc = 0;
        for (int c = 1; c <= 200; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (done0) begin cyc = c; break; end
        end
    endtask

    initial begin
        int cyc, bad;
        repeat (3) @(posedge clk);
        #1;
        chk_stats("reset", 0, 0, 0, 0, 0, 0);
        chk("reset busy", int'(busy0), 0);
        chk("reset done", int'(done0), 0);
        chk("reset dut_in", int'(din0), 0);
        rst = 1'b0;

        mode = 0;
        sweep0(cyc);
        chk("exact done cycle", cyc, 33);
        chk("exact busy at done", int'(busy0), 0);
        chk_stats("exact", 1, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 chk("exact pass held", int'(pass0), 1);
        chk("exact done one cycle", int'(done0), 0);

        mode = 1;
        sweep0(cyc);
`ifdef ERR_MONITOR_STOP_ON_FAIL_EN
        chk("zero done cycle", cyc, 9);
        chk_stats("zero", 0, 3, 3, 1, 6, 3);
`else
        chk("zero done cycle", cyc, 33);
        chk_stats("zero", 0, 6, 15, 10, 48, 3);
`endif

        mode = 2;
        sweep0(cyc);
        chk("inject done cycle", cyc, 33);
        chk_stats("inject", 1, 2, 1, 0, 2, 0);

        mode = 3;
        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        bad = 1;
        for (int c = 0; c < 40; c++) begin
            if (din0 == 4'd7) begin bad = 0; break; end
            @(posedge clk); #1;
        end
        chk("reached vec 7", bad, 0);
        chk("err_cnt before abort", int'(ec0), 7);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk_stats("abort", 0, 0, 0, 0, 0, 0);
        chk("abort busy", int'(busy0), 0);
        chk("abort dut_in", int'(din0), 0);
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done0 || busy0) bad++;
        end
        chk("no done after abort", bad, 0);
        mode = 0;
        sweep0(cyc);
        chk("restart done cycle", cyc, 33);
        chk_stats("restart", 1, 0, 0, 0, 0, 0);

        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        cyc = 0;
        bad = 0;
        for (int c = 1; c <= 200; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            start1 = c == 20;
            if (done1) begin cyc = c; break; end
            if (int'(din1) != (c - 1) / 5 || !busy1) bad++;
        end
        start1 = 1'b0;
        chk("settle3 done cycle", cyc, 81);
        chk("settle3 vector schedule", bad, 0);
        chk("settle3 pass", int'(pass1), 1);
        chk("settle3 err_cnt", int'(ec1), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
